input_conditioner: RTL

Input-side front end for the counter board: it takes the raw push-buttons (active-low) and slide switches and delivers clean, glitch-free signals to the counter control logic. Each button gets a two-flop synchroniser, a debouncer and an edge detector. Held buttons optionally auto-repeat. Switches are synchronised only. It is the read-side counterpart of the display/LED output register stage and sits between the board pins and the counter core.

---
 rtl/input_conditioner.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/input_conditioner.sv
// input_conditioner: board-pin front end for the counter core.
// Push-buttons (active-low) get a two-flop synchroniser, a per-key debouncer,
// registered press/release edge pulses and an optional auto-repeat engine.
// Slide switches are only synchronised.

module input_conditioner #(
    parameter int N_KEYS          = 4,
    parameter int N_SW            = 10,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 5_000_000
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [N_KEYS-1:0] i_keys_n,
    input  logic [N_SW-1:0]   i_sw,
    input  logic              i_repeat_en,
    output logic [N_KEYS-1:0] o_keys,
    output logic [N_KEYS-1:0] o_press,
    output logic [N_KEYS-1:0] o_release,
    output logic [N_SW-1:0]   o_sw
);

    // $clog2(N) bits always hold N-1, which is the largest value a counter reaches.
    localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RCNT_W  = $clog2(REP_MAX);

    localparam logic [CNT_W-1:0]  DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  DB_ONE      = CNT_W'(1);
    localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);
    localparam logic [RCNT_W-1:0] RCNT_ONE    = RCNT_W'(1);

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        HOLD_DELAY  = 2'd1,
        HOLD_REPEAT = 2'd2
    } rep_state_t;

    // Synchroniser stages; keys are inverted on entry so 1 means pressed internally.
    logic [N_KEYS-1:0] key_meta;
    logic [N_KEYS-1:0] key_sync;
    logic [N_SW-1:0]   sw_meta;
    logic [N_SW-1:0]   sw_sync;

    // Per-key debounce results and repeat requests gathered into vectors.
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] accept_press;
    logic [N_KEYS-1:0] accept_release;
    logic [N_KEYS-1:0] repeat_pulse;

    // Edge pulse registers.
    logic [N_KEYS-1:0] press_q;
    logic [N_KEYS-1:0] release_q;

    // Two-flop synchronisers for every key and switch bit.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            key_meta <= '0;
            key_sync <= '0;
            sw_meta  <= '0;
            sw_sync  <= '0;
        end else begin
            key_meta <= ~i_keys_n;
            key_sync <= key_meta;
            sw_meta  <= i_sw;
            sw_sync  <= sw_meta;
        end
    end

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        logic              level_q;
        logic [CNT_W-1:0]  cnt_q;
        logic              mismatch;
        logic              accept;

        rep_state_t        state_q;
        rep_state_t        state_d;
        logic [RCNT_W-1:0] rcnt_q;
        logic [RCNT_W-1:0] rcnt_d;
        logic              pulse_d;

        // A level change is accepted only after DEBOUNCE_CYCLES consecutive mismatching cycles.
        assign mismatch = (key_sync[k] != level_q);
        assign accept   = mismatch && (cnt_q == DB_LAST);

        assign accept_press[k]   = accept &&  key_sync[k];
        assign accept_release[k] = accept && !key_sync[k];
        assign key_level[k]      = level_q;
        assign repeat_pulse[k]   = pulse_d;

        // Debounce counter: any matching cycle restarts the count, so short bounces vanish.
        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                level_q <= 1'b0;
                cnt_q   <= '0;
            end else if (!mismatch) begin
                cnt_q <= '0;
            end else if (accept) begin
                level_q <= key_sync[k];
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + DB_ONE;
            end
        end

        // Auto-repeat state and hold counter registers.
        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                state_q <= RELEASED;
                rcnt_q  <= '0;
            end else begin
                state_q <= state_d;
                rcnt_q  <= rcnt_d;
            end
        end

        // Auto-repeat next state; an accepted release overrides a repeat due in the same cycle.
        always_comb begin
            state_d = state_q;
            rcnt_d  = rcnt_q;
            pulse_d = 1'b0;
            if (accept_release[k]) begin
                state_d = RELEASED;
                rcnt_d  = '0;
            end else begin
                case (state_q)
                    RELEASED: begin
                        if (accept_press[k]) begin
                            state_d = HOLD_DELAY;
                            rcnt_d  = '0;
                        end
                    end
                    HOLD_DELAY: begin
                        if (rcnt_q == DELAY_LAST) begin
                            if (i_repeat_en) begin
                                pulse_d = 1'b1;
                                rcnt_d  = '0;
                                state_d = HOLD_REPEAT;
                            end
                        end else begin
                            rcnt_d = rcnt_q + RCNT_ONE;
                        end
                    end
                    HOLD_REPEAT: begin
                        if (rcnt_q == PERIOD_LAST) begin
                            pulse_d = i_repeat_en;
                            rcnt_d  = '0;
                        end else begin
                            rcnt_d = rcnt_q + RCNT_ONE;
                        end
                    end
                    default: begin
                        state_d = RELEASED;
                        rcnt_d  = '0;
                    end
                endcase
            end
        end
    end

    // Registered one-cycle pulses, aligned with the o_keys update edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            press_q   <= '0;
            release_q <= '0;
        end else begin
            press_q   <= accept_press | repeat_pulse;
            release_q <= accept_release;
        end
    end

    assign o_keys    = key_level;
    assign o_press   = press_q;
    assign o_release = release_q;
    assign o_sw      = sw_sync;

endmodule
